keypad_reader: RTL and testbench



---
 rtl/keypad_pkg.sv | 46 ++++
 rtl/keypad_reader_if.sv | 11 +
 rtl/keypad_reader_sync.sv | 22 ++
 rtl/keypad_reader.sv | 126 ++++++++++++
 tb/tb_keypad_reader.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad reader: FSM states, special key
// codes, the key map and the single-row-low detector.
package keypad_pkg;

   typedef enum logic [2:0] {SCAN, DEBOUNCE, COMMIT, HOLD, REL_DB} kp_state_t;

   localparam logic [3:0] KEY_BKSP = 4'hE;
   localparam logic [3:0] KEY_CLR  = 4'hF;

   function automatic logic [3:0] kp_map(input logic [1:0] row_idx, input logic [1:0] col_idx);
      logic [3:0] code;
      case ({row_idx, col_idx})
         4'h0: code = 4'h1;
         4'h1: code = 4'h2;
         4'h2: code = 4'h3;
         4'h3: code = 4'hA;
         4'h4: code = 4'h4;
         4'h5: code = 4'h5;
         4'h6: code = 4'h6;
         4'h7: code = 4'hB;
         4'h8: code = 4'h7;
         4'h9: code = 4'h8;
         4'hA: code = 4'h9;
         4'hB: code = 4'hC;
         4'hC: code = KEY_BKSP;
         4'hD: code = 4'h0;
         4'hE: code = KEY_CLR;
         default: code = 4'hD;
      endcase
      return code;
   endfunction

   // {valid, idx}: valid only when exactly one row is pulled low
   function automatic logic [2:0] onehot_low(input logic [3:0] rows);
      logic [2:0] res;
      case (rows)
         4'b1110: res = 3'b100;
         4'b1101: res = 3'b101;
         4'b1011: res = 3'b110;
         4'b0111: res = 3'b111;
         default: res = 3'b000;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/keypad_reader_if.sv
// CPU-side keypad read path: read strobe in, assembled value and key status out.
interface keypad_reader_if;
   logic        board_ctrl;
   logic [15:0] io_rdata_board;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_pending;

   modport slave  (input board_ctrl, output io_rdata_board, key_valid, key_code, key_pending);
   modport master (output board_ctrl, input io_rdata_board, key_valid, key_code, key_pending);
endinterface

// File: rtl/keypad_reader_sync.sv
// Two-flop synchroniser for asynchronous level inputs (rows, switches, buttons).
module sync_2ff #(
   parameter int             W       = 4,
   parameter logic [W-1:0]   RST_VAL = 4'hF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/keypad_reader.sv
// 4x4 keypad scanner: column scan, press/release debounce, and assembly of
// accepted keys into a 16-bit hex value readable over the board bus.
module keypad_reader import keypad_pkg::*; #(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CYC = 200000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       row_in,
   output logic [3:0]       col_out,
   keypad_reader_if.slave   bus
);
   localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] SCAN_END = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_END  = CW'(DEBOUNCE_CYC - 1);

   kp_state_t     state, nxt_state;
   logic [3:0]    rs;
   logic [2:0]    oh;
   logic [CW-1:0] cnt;
   logic [1:0]    col_idx, row_idx;
   logic [3:0]    row_pat;
   logic [3:0]    code;
   logic [15:0]   value;
   logic          pending;
   logic          cnt_clr, col_inc, latch;

   sync_2ff #(.W(4), .RST_VAL(4'hF)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (row_in),
      .q     (rs)
   );

   assign oh = onehot_low(rs);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= SCAN;
      else        state <= nxt_state;
   end

   always_comb begin
      nxt_state = state;
      cnt_clr   = 1'b0;
      col_inc   = 1'b0;
      latch     = 1'b0;
      unique case (state)
         SCAN: begin
            if (cnt == SCAN_END) begin
               cnt_clr = 1'b1;
               if (oh[2]) begin
                  latch     = 1'b1;
                  nxt_state = DEBOUNCE;
               end else begin
                  col_inc = 1'b1;
               end
            end
         end
         DEBOUNCE: begin
            if (rs != row_pat) begin
               col_inc   = 1'b1;
               nxt_state = SCAN;
            end else if (cnt == DEB_END) begin
               nxt_state = COMMIT;
            end
         end
         COMMIT: nxt_state = HOLD;
         HOLD: begin
            if (rs == 4'hF) nxt_state = REL_DB;
         end
         REL_DB: begin
            if (rs != 4'hF) begin
               nxt_state = HOLD;
            end else if (cnt == DEB_END) begin
               col_inc   = 1'b1;
               nxt_state = SCAN;
            end
         end
         default: nxt_state = SCAN;
      endcase
      if (nxt_state != state) cnt_clr = 1'b1;
   end

   always_comb begin
      col_out       = ~(4'b0001 << col_idx);
      bus.key_valid = (state == COMMIT);
   end

   // key_code is loaded on entry to COMMIT so it is valid alongside key_valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         col_idx <= 2'd0;
         row_idx <= 2'd0;
         row_pat <= 4'hF;
         code    <= 4'h0;
         value   <= 16'h0000;
         pending <= 1'b0;
      end else begin
         cnt <= cnt_clr ? '0 : cnt + 1'b1;
         if (col_inc) col_idx <= col_idx + 2'd1;
         if (latch) begin
            row_pat <= rs;
            row_idx <= oh[1:0];
         end
         if (state == DEBOUNCE && nxt_state == COMMIT)
            code <= kp_map(row_idx, col_idx);
         if (state == COMMIT) begin
            case (code)
               KEY_BKSP: value <= value >> 4;
               KEY_CLR:  value <= 16'h0000;
               default:  value <= {value[11:0], code};
            endcase
         end
         // a key accepted in the same cycle as a read stays pending
         if (state == COMMIT)      pending <= 1'b1;
         else if (bus.board_ctrl)  pending <= 1'b0;
      end
   end

   assign bus.io_rdata_board = value;
   assign bus.key_code       = code;
   assign bus.key_pending    = pending;

endmodule

// File: tb/tb_keypad_reader.sv
// Scoreboarded bench for keypad_reader with a behavioural keypad matrix model.
module tb_keypad_reader;
   localparam int SD = 4;
   localparam int DB = 8;

   typedef struct {
      logic [3:0]  code;
      logic [15:0] val;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  row_in, col_out;
   logic [15:0] pressed = 16'h0000;

   exp_t  q[$];
   int    checks = 0, failures = 0, commits = 0;
   int    model_val = 0;
   string keys = "123A456B789C*0#D";

   keypad_reader_if bus();

   keypad_reader #(.SCAN_DIV(SD), .DEBOUNCE_CYC(DB)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .row_in  (row_in),
      .col_out (col_out),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // A pressed key shorts its row to its column; rows are pulled up otherwise
   function automatic logic [3:0] rows_of(input logic [3:0] col, input logic [15:0] p);
      logic [3:0] r = 4'hF;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            if (p[i*4+j] && !col[j]) r[i] = 1'b0;
      return r;
   endfunction

   assign row_in = rows_of(col_out, pressed);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic int code_of(input int k);
      byte ch = keys[k];
      if (ch == "*") return 14;
      if (ch == "#") return 15;
      if (ch >= "0" && ch <= "9") return int'(ch) - int'("0");
      return int'(ch) - int'("A") + 10;
   endfunction

   task automatic push_exp(input int k);
      exp_t e;
      int   c = code_of(k);
      if (c == 14)      model_val = model_val / 16;
      else if (c == 15) model_val = 0;
      else              model_val = (model_val * 16 + c) % 65536;
      e.code = 4'(c);
      e.val  = 16'(model_val);
      q.push_back(e);
   endtask

   task automatic press(input int k, input int hold);
      push_exp(k);
      pressed[k] = 1'b1;
      cycles(hold);
      pressed[k] = 1'b0;
      cycles(30);
   endtask

   task automatic ghost(input int c, input int r0, input int r1);
      pressed[r0*4+c] = 1'b1;
      pressed[r1*4+c] = 1'b1;
      cycles(40);
      pressed = 16'h0000;
      cycles(30);
   endtask

   task automatic read_pulse();
      bus.board_ctrl = 1'b1;
      @(negedge clk);
      bus.board_ctrl = 1'b0;
      chk("pending_cleared_by_read", bus.key_pending, 1'b0);
   endtask

   // Monitor: every key_valid pops one expectation; value and pending follow a cycle later
   initial begin
      exp_t cur;
      logic post = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            post = 1'b0;
         end else begin
            if (post) begin
               chk("value", bus.io_rdata_board, cur.val);
               chk("pending_after_key", bus.key_pending, 1'b1);
               post = 1'b0;
            end
            if (bus.key_valid) begin
               commits++;
               if (q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_key_valid: got code %0h expected no key", bus.key_code);
               end else begin
                  cur = q.pop_front();
                  chk("key_code", bus.key_code, cur.code);
                  post = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      int c0, same, nchg, found, k;
      logic [3:0] prev;
      bus.board_ctrl = 1'b0;
      cycles(3);
      chk("rst_col_out", col_out, 4'b1110);
      chk("rst_rdata", bus.io_rdata_board, 16'h0);
      chk("rst_key_valid", bus.key_valid, 1'b0);
      chk("rst_key_code", bus.key_code, 4'h0);
      chk("rst_pending", bus.key_pending, 1'b0);
      rst_n = 1'b1;
      cycles(5);

      // single key '5'
      c0 = commits;
      press(5, 50);
      chk("five_commits", commits - c0, 1);
      chk("five_value", bus.io_rdata_board, 16'h0005);
      chk("five_code", bus.key_code, 4'h5);
      chk("five_pending", bus.key_pending, 1'b1);
      read_pulse();

      // 1 2 3 A B, then backspace and clear
      press(0, 50); press(1, 50); press(2, 50); press(3, 50); press(7, 50);
      chk("value_23ab", bus.io_rdata_board, 16'h23AB);
      press(12, 50);
      chk("value_023a", bus.io_rdata_board, 16'h023A);
      press(14, 50);
      chk("value_clr", bus.io_rdata_board, 16'h0000);
      chk("code_clr", bus.key_code, 4'hF);
      press(8, 50);

      // reset while debouncing '1': wait for column 0 to be frozen
      c0 = commits;
      pressed[0] = 1'b1;
      same = 0;
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         same = (col_out == 4'b1110) ? same + 1 : 0;
         if (same >= 5) found = 1;
      end
      chk("debounce_reached", found, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_col_out", col_out, 4'b1110);
      chk("mid_rst_rdata", bus.io_rdata_board, 16'h0);
      chk("mid_rst_key_valid", bus.key_valid, 1'b0);
      chk("mid_rst_key_code", bus.key_code, 4'h0);
      chk("mid_rst_pending", bus.key_pending, 1'b0);
      q.delete();
      model_val = 0;
      @(negedge clk);
      pressed[0] = 1'b0;
      cycles(3);
      rst_n = 1'b1;
      cycles(40);
      chk("no_commit_after_reset", commits - c0, 0);

      // bounce on r0/c2
      c0 = commits;
      pressed[2] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycles(3);
         pressed[2] = ~pressed[2];
      end
      pressed[2] = 1'b0;
      cycles(12);
      chk("bounce_no_commit", commits - c0, 0);
      prev = col_out;
      nchg = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (col_out != prev) begin
            chk("col_rotate", col_out, {prev[2:0], prev[3]});
            prev = col_out;
            nchg++;
         end
      end
      chk("col_cycles", nchg >= 4, 1'b1);

      // ghost, then a long '9' hold
      c0 = commits;
      ghost(0, 0, 1);
      chk("ghost_no_commit", commits - c0, 0);
      press(10, 200);
      chk("hold_single_commit", commits - c0, 1);

      // read coinciding with key_valid
      push_exp(15);
      pressed[15] = 1'b1;
      found = 0;
      for (int i = 0; i < 80 && !found; i++) begin
         @(negedge clk);
         if (bus.key_valid) found = 1;
      end
      chk("coincide_key_seen", found, 1);
      bus.board_ctrl = 1'b1;
      @(negedge clk);
      chk("coincide_pending", bus.key_pending, 1'b1);
      @(negedge clk);
      bus.board_ctrl = 1'b0;
      chk("next_read_pending", bus.key_pending, 1'b0);
      pressed[15] = 1'b0;
      cycles(30);

      // randomized keys, ghosts and reads
      for (int n = 0; n < 20; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            k = $urandom_range(0, 2);
            ghost($urandom_range(0, 3), k, k + 1);
         end else begin
            press($urandom_range(0, 15), $urandom_range(45, 90));
         end
         if ($urandom_range(0, 1) == 1) read_pulse();
      end

      cycles(10);
      chk("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
